// File: rtl/alu_iter_unit.sv
// Handshaked multi-cycle ALU: logic/arith ops complete in one cycle,
// shifts iterate one bit position per cycle; result held until consumed.
module alu_iter_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_r,
    input  logic [31:0] i_s,
    input  logic [3:0]  i_aluc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_alu,
    output logic        o_zero
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] shreg_q, shreg_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic        left_q,  left_d;
    logic        arith_q, arith_d;
    logic [31:0] res_q,   res_d;
    logic        zero_q,  zero_d;

    logic        isShift;
    logic [31:0] quickRes;
    logic [31:0] shifted;

    assign isShift = (i_aluc[1:0] == 2'b11);
    assign shifted = left_q ? {shreg_q[30:0], 1'b0}
                            : {arith_q & shreg_q[31], shreg_q[31:1]};

    // A shift by zero falls into the default arm and returns s unchanged.
    always_comb begin
        quickRes = i_s;
        case (i_aluc[2:0])
            3'b000:  quickRes = i_r + i_s;
            3'b100:  quickRes = i_r - i_s;
            3'b001:  quickRes = i_r & i_s;
            3'b101:  quickRes = i_r | i_s;
            3'b010:  quickRes = i_r ^ i_s;
            3'b110:  quickRes = {i_s[15:0], 16'h0000};
            default: quickRes = i_s;
        endcase
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
        res_d   = res_q;
        zero_d  = zero_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    if (isShift && (i_r[4:0] != 5'd0)) begin
                        shreg_d = i_s;
                        cnt_d   = i_r[4:0];
                        left_d  = ~i_aluc[2];
                        arith_d = i_aluc[3];
                        state_d = SHIFT;
                    end else begin
                        res_d   = quickRes;
                        zero_d  = (quickRes == 32'd0);
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                shreg_d = shifted;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    res_d   = shifted;
                    zero_d  = (shifted == 32'd0);
                    state_d = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            shreg_q <= 32'd0;
            cnt_q   <= 5'd0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
            res_q   <= 32'd0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            arith_q <= arith_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    assign o_alu  = res_q;
    assign o_zero = zero_q;

endmodule

// File: tb/tb_alu_iter_unit.sv
// Self-checking bench for alu_iter_unit: directed cases from the test plan
// plus randomized requests against an arithmetic reference model.
module tb_alu_iter_unit;

    logic        clk;
    logic        rstN;
    logic        inValid;
    logic        outReady;
    logic [31:0] opR;
    logic [31:0] opS;
    logic [3:0]  opAluc;
    logic        outValid;
    logic        consReady;
    logic [31:0] aluOut;
    logic        zeroOut;

    int vecCount = 0;
    int errCount = 0;

    logic        pendOn;
    logic [31:0] pendR;
    logic [31:0] pendS;
    logic [3:0]  pendAluc;

    alu_iter_unit dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .i_valid (inValid),
        .o_ready (outReady),
        .i_r     (opR),
        .i_s     (opS),
        .i_aluc  (opAluc),
        .o_valid (outValid),
        .i_ready (consReady),
        .o_alu   (aluOut),
        .o_zero  (zeroOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result straight from the operation table.
    function automatic logic [31:0] refAlu(input logic [31:0] r, input logic [31:0] s,
                                           input logic [3:0] aluc);
        logic [31:0] res;
        res = 32'd0;
        casez (aluc)
            4'b?000: res = r + s;
            4'b?100: res = r - s;
            4'b?001: res = r & s;
            4'b?101: res = r | s;
            4'b?010: res = r ^ s;
            4'b?110: res = s << 16;
            4'b?011: res = s << r[4:0];
            4'b0111: res = s >> r[4:0];
            4'b1111: res = $unsigned($signed(s) >>> r[4:0]);
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    function automatic int refLatency(input logic [31:0] r, input logic [3:0] aluc);
        if (aluc[1:0] == 2'b11) return int'(r[4:0]) + 1;
        return 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One full transaction: wait for ready, accept, time the result,
    // optionally stall the consumer, then hand the result off.
    task automatic applyStimulus(input string tag, input logic [31:0] r, input logic [31:0] s,
                                 input logic [3:0] aluc, input int stall, input bit scramble);
        int          t;
        int          lat;
        bit          readyLow;
        logic [31:0] expRes;
        int          expLat;
        expRes = refAlu(r, s, aluc);
        expLat = refLatency(r, aluc);
        @(negedge clk);
        t = 0;
        while (!outReady && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!outReady) begin
            checkOutput({tag, " ready timeout"}, 32'd0, 32'd1);
            return;
        end
        inValid = 1'b1;
        opR     = r;
        opS     = s;
        opAluc  = aluc;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        if (scramble) begin
            opR    = $urandom;
            opS    = $urandom;
            opAluc = 4'($urandom_range(0, 15));
        end
        lat      = 1;
        readyLow = 1'b1;
        while (!outValid && lat < 100) begin
            if (outReady) readyLow = 1'b0;
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        if (expLat > 1) checkOutput({tag, " ready low while shifting"}, 32'(readyLow), 32'd1);
        checkOutput({tag, " result"}, aluOut, expRes);
        checkOutput({tag, " zero"}, 32'(zeroOut), 32'(expRes == 32'd0));
        checkOutput({tag, " ready low in done"}, 32'(outReady), 32'd0);
        if (stall > 0) begin
            consReady = 1'b0;
            if (pendOn) begin
                inValid = 1'b1;
                opR     = pendR;
                opS     = pendS;
                opAluc  = pendAluc;
            end
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                checkOutput({tag, " stall valid"}, 32'(outValid), 32'd1);
                checkOutput({tag, " stall result"}, aluOut, expRes);
                checkOutput({tag, " stall ready"}, 32'(outReady), 32'd0);
            end
            consReady = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput({tag, " valid after take"}, 32'(outValid), 32'd0);
        checkOutput({tag, " ready after take"}, 32'(outReady), 32'd1);
    endtask

    initial begin
        bit          sawValid;
        logic [31:0] rr;
        logic [31:0] ss;
        logic [3:0]  aa;
        pendOn    = 1'b0;
        pendR     = 32'd0;
        pendS     = 32'd0;
        pendAluc  = 4'd0;
        rstN      = 1'b0;
        inValid   = 1'b0;
        consReady = 1'b1;
        opR       = 32'd0;
        opS       = 32'd0;
        opAluc    = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ready", 32'(outReady), 32'd1);
        checkOutput("reset valid", 32'(outValid), 32'd0);
        checkOutput("reset alu", aluOut, 32'd0);
        checkOutput("reset zero", 32'(zeroOut), 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        applyStimulus("add", 32'h87654321, 32'd5, 4'b1000, 0, 1'b0);
        applyStimulus("sub", 32'h87654321, 32'd5, 4'b1100, 0, 1'b0);
        applyStimulus("or",  32'h87654321, 32'd5, 4'b1101, 0, 1'b0);
        applyStimulus("and", 32'h87654321, 32'd5, 4'b0001, 0, 1'b0);
        applyStimulus("xor", 32'h87654321, 32'd5, 4'b0010, 0, 1'b0);
        applyStimulus("lui", 32'h87654321, 32'd5, 4'b0110, 0, 1'b0);

        applyStimulus("sra4", 32'd4, 32'h80000000, 4'b1111, 0, 1'b0);
        applyStimulus("srl4", 32'd4, 32'h80000000, 4'b0111, 0, 1'b0);
        applyStimulus("sll4", 32'd4, 32'h80000000, 4'b0011, 0, 1'b0);

        applyStimulus("shift0",  32'h20, 32'h1234, 4'b0011, 0, 1'b0);
        applyStimulus("sra31",   32'd31, 32'h80000000, 4'b1111, 0, 1'b0);
        applyStimulus("subzero", 32'hDEADBEEF, 32'hDEADBEEF, 4'b0100, 0, 1'b0);

        pendOn   = 1'b1;
        pendR    = 32'd100;
        pendS    = 32'd23;
        pendAluc = 4'b0000;
        applyStimulus("stall", 32'h0F0F0F0F, 32'h00FF00FF, 4'b0101, 3, 1'b0);
        pendOn   = 1'b0;
        applyStimulus("pending", pendR, pendS, pendAluc, 0, 1'b0);

        applyStimulus("scramble add", 32'h11111111, 32'h22222222, 4'b0000, 0, 1'b1);
        applyStimulus("scramble sra", 32'd7, 32'hF0000000, 4'b1111, 0, 1'b1);

        @(negedge clk);
        inValid = 1'b1;
        opR     = 32'd20;
        opS     = 32'h80000000;
        opAluc  = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        repeat (3) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("midreset valid", 32'(outValid), 32'd0);
        checkOutput("midreset ready", 32'(outReady), 32'd1);
        checkOutput("midreset alu", aluOut, 32'd0);
        checkOutput("midreset zero", 32'(zeroOut), 32'd0);
        @(negedge clk);
        rstN     = 1'b1;
        sawValid = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (outValid) sawValid = 1'b1;
        end
        checkOutput("no stale result", 32'(sawValid), 32'd0);
        applyStimulus("fresh add", 32'd2, 32'd3, 4'b0000, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rr = $urandom;
            ss = $urandom;
            aa = 4'($urandom_range(0, 15));
            applyStimulus("random", rr, ss, aa, int'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/alu_iter_unit.md
# alu_iter_unit

Handshaked, multi-cycle ALU responder for the pipeline CPU's execute path. It accepts one operation request (operands plus 4-bit ALU control) over a valid/ready channel and computes it. Logic ops finish in one cycle; shifts run one bit position per cycle. The result is returned over a second valid/ready channel and held until the consumer takes it, so the block can stand in for the single-cycle ALU where area matters or results must be stalled.

## Interface
- No parameters; data width fixed at 32.
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid && o_ready at a clock edge
- i_r  in  32  operand r (shift amount taken from i_r[4:0])
- i_s  in  32  operand s (value shifted for shift ops)
- i_aluc  in  4  operation select
- o_valid  out  1  result valid
- i_ready  in  1  consumer takes result when o_valid && i_ready at a clock edge
- o_alu  out  32  result
- o_zero  out  1  o_alu == 0, meaningful while o_valid

## Operation
- Encoding: x000 ADD r+s; x100 SUB r−s; x001 AND; x101 OR; x010 XOR; x110 LUI s<<16; x011 SLL s<<r[4:0]; 0111 SRL; 1111 SRA (arithmetic, sign = s[31]).
- All arithmetic is modulo 2^32; no overflow flag; carry discarded.
- Operands and aluc are captured into internal registers on accept; later input changes have no effect.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: o_ready=1, o_valid=0. On accept with a non-shift op → result registered, go to DONE. On a shift op with amount 0 → o_alu=s, go to DONE. On a shift op with amount k>0 → load s into the shift register and k into the 5-bit countdown, go to SHIFT.
  - SHIFT: o_ready=0. Each cycle, shift by one bit (SLL fills 0, SRL fills 0, SRA fills s[31]) and decrement the count. When the count reaches 0 after the shift, go to DONE.
  - DONE: o_valid=1, o_ready=0. o_alu and o_zero are stable. On i_ready → IDLE.
- No request overlap: a new request is accepted only in IDLE, including the cycle after a result handshake.
- i_valid while busy is ignored (not queued). The requester must hold its request until o_ready.
- Reset (any state, including mid-shift): state←IDLE, o_ready=1, o_valid=0, o_alu=0, o_zero=0 (forced low, not derived), internal regs←0. Aborted operation produces no result.

## Timing
- Accept at edge N.
- Non-shift op or shift by 0: o_valid high after edge N+1.
- Shift by k (1..31): o_valid high after edge N+1+k.
- o_valid stays high until the edge where i_ready=1. o_valid falls and o_ready rises after that edge.
- Throughput with i_ready tied high: one non-shift op every 2 cycles.
- o_alu holds its last value while in IDLE and SHIFT. o_alu is only meaningful when o_valid=1.
- Reset deassertion is synchronized externally. The first accept is possible at the first edge after i_rst_n rises.

## Test plan
- i_r=0x87654321, i_s=5, i_ready=1: the bench must check each op.
  - aluc 1000 → 0x87654326
  - aluc 1100 → 0x8765431C
  - aluc 1101 → 0x87654325
  - aluc 0001 → 0x00000001
  - aluc 0010 → 0x87654324
  - aluc 0110 → 0x00050000
  - Each op: o_valid exactly 1 cycle after accept, o_zero=0.
- Shifts with i_r=4, i_s=0x80000000:
  - aluc 1111 → 0xF8000000
  - aluc 0111 → 0x08000000
  - aluc 0011 → 0x00000000 with o_zero=1
  - Each: o_valid 5 cycles after accept, o_ready low throughout.
- Shift boundaries:
  - i_r=0x20 (amount 0), aluc 0011, i_s=0x1234 → 0x1234 after 1 cycle.
  - i_r=31, aluc 1111, i_s=0x80000000 → 0xFFFFFFFF after 32 cycles.
- Backpressure: i_ready=0 for 3 cycles after o_valid → o_alu/o_valid stable, o_ready=0. A second i_valid during that window is not accepted. After i_ready=1, o_ready=1 next cycle and the pending request is accepted.
- Input change after accept: alter i_r/i_s/i_aluc in the cycle after accept → result still matches the captured values.
- Reset mid-shift: assert i_rst_n=0 during SHIFT → immediately o_valid=0, o_ready=1, o_alu=0. After release, no stale result appears and a fresh ADD 2+3 returns 5.
